gap_runner_engine: RTL and testbench

- Parametrised vertical-scroller engine: player square steered by mouse dx dodges NUM_OBST falling bars, each with one gap.
- Sits between mouse decoder/PRNG and the pixel mixer. Answers per-pixel "obstacle here?" / "player here?" queries combinationally.
- Adds explicit FSM, clamped signed movement, shrinking gap, saturating score and registered collision.

---
 rtl/gap_runner_pkg.sv | 37 +++
 rtl/gap_runner_bar.sv | 80 ++++++++
 rtl/gap_runner_engine.sv | 176 +++++++++++++++++
 tb/tb_gap_runner_engine.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gap_runner_pkg.sv
// Shared types and widths for the gap runner engine: FSM encodings, coordinate
// widths and the per-bar state record.
package gap_runner_pkg;

  localparam int FIELD_W_DEF = 400;
  localparam int FIELD_H_DEF = 600;

  localparam int X_W  = $clog2(FIELD_W_DEF);
  localparam int Y_W  = $clog2(FIELD_H_DEF);
  // Bar tops start above the screen, so they need a sign bit plus headroom.
  localparam int YS_W = Y_W + 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_LOSE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_PAUSE = ST_PAUSE,
    S_LOSE  = ST_LOSE
  } state_e;

  typedef struct packed {
    logic signed [YS_W-1:0] y;
    logic [X_W-1:0]         left;
    logic [X_W-1:0]         right;
  } bar_t;

  function automatic int clamp_int(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/gap_runner_bar.sv
// One falling bar: scrolls on tick, respawns above the field with a new gap,
// and reports its own collision and pixel-coverage flags.
module gap_runner_bar
  import gap_runner_pkg::*;
#(
  parameter int IDX        = 0,
  parameter int FIELD_W    = 400,
  parameter int FIELD_H    = 600,
  parameter int NUM_OBST   = 5,
  parameter int OBST_H     = 20,
  parameter int OBST_PITCH = 140,
  parameter int PLAYER_R   = 10,
  parameter int HOLE_INIT  = 75
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic           i_init,
  input  logic           i_tick,
  input  logic [2:0]     i_step,
  input  logic [X_W-1:0] i_hole,
  input  logic [7:0]     i_rand,
  input  logic [X_W-1:0] i_ball_x,
  input  logic [Y_W-1:0] i_ball_y,
  input  logic [X_W-1:0] i_screen_x,
  input  logic [Y_W-1:0] i_screen_y,
  output logic           o_respawn,
  output logic           o_hit,
  output logic           o_pix
);

  localparam logic signed [YS_W-1:0] Y_INIT = YS_W'(-(IDX + 1) * OBST_PITCH);
  localparam logic [X_W-1:0] L_INIT = X_W'(FIELD_W / 2 - HOLE_INIT);
  localparam logic [X_W-1:0] R_INIT = X_W'(FIELD_W / 2 + HOLE_INIT);

  bar_t bar_q, bar_d;
  int   y_i, hole_i, cen, bx, by, sx, sy, lf, rt;

  always_comb begin
    y_i    = int'($signed(bar_q.y));
    hole_i = int'(i_hole);
    lf     = int'(bar_q.left);
    rt     = int'(bar_q.right);
    bx     = int'(i_ball_x);
    by     = int'(i_ball_y);
    sx     = int'(i_screen_x);
    sy     = int'(i_screen_y);

    o_respawn = i_tick && (y_i >= FIELD_H);
    // Gap centre follows the PRNG but the whole gap must stay on screen.
    cen = clamp_int(FIELD_W / 2 + int'($signed(i_rand)), hole_i, FIELD_W - 1 - hole_i);

    bar_d = bar_q;
    if (i_init) begin
      bar_d.y     = Y_INIT;
      bar_d.left  = L_INIT;
      bar_d.right = R_INIT;
    end else if (o_respawn) begin
      bar_d.y     = YS_W'(y_i - NUM_OBST * OBST_PITCH);
      bar_d.left  = X_W'(cen - hole_i);
      bar_d.right = X_W'(cen + hole_i);
    end else if (i_tick) begin
      bar_d.y = YS_W'(y_i + int'(i_step));
    end

    o_hit = (by - PLAYER_R <= y_i + OBST_H - 1) && (y_i <= by + PLAYER_R) &&
            ((bx - PLAYER_R < lf) || (bx + PLAYER_R > rt));
    o_pix = (sy >= y_i) && (sy <= y_i + OBST_H - 1) && ((sx < lf) || (sx > rt));
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bar_q.y     <= Y_INIT;
      bar_q.left  <= L_INIT;
      bar_q.right <= R_INIT;
    end else begin
      bar_q <= bar_d;
    end
  end

endmodule

// File: rtl/gap_runner_engine.sv
// Vertical scroller engine: player square dodges NUM_OBST falling gapped bars.
// Define GAP_RUNNER_SPEEDUP_EN to make the scroll step grow with the score.
module gap_runner_engine
  import gap_runner_pkg::*;
#(
  parameter int FIELD_W    = 400,
  parameter int FIELD_H    = 600,
  parameter int NUM_OBST   = 5,
  parameter int OBST_H     = 20,
  parameter int OBST_PITCH = 140,
  parameter int PLAYER_R   = 10,
  parameter int TICK_W     = 15,
  parameter int HOLE_INIT  = 75,
  parameter int HOLE_MIN   = 30,
  parameter int SCORE_W    = 10
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic [7:0]         i_mouse_dx,
  input  logic               i_mouse_dx_neg,
  input  logic [7:0]         i_rand,
  input  logic               i_start,
  input  logic               i_pause,
  input  logic [X_W-1:0]     i_screen_x,
  input  logic [Y_W-1:0]     i_screen_y,
  output logic               o_is_obstacle,
  output logic               o_is_player,
  output logic [X_W-1:0]     o_ball_x,
  output logic [Y_W-1:0]     o_ball_y,
  output logic [1:0]         o_state,
  output logic [SCORE_W-1:0] o_score,
  output logic [1:0]         o_level
);

  localparam int BALL_Y    = FIELD_H - 100;
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

  logic [1:0]         state_q, state_d;
  logic [X_W-1:0]     ball_x_q, ball_x_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [X_W-1:0]     hole_q, hole_d;
  logic [TICK_W-1:0]  timer_q, timer_d;

  logic [NUM_OBST-1:0] respawn_v, hit_v, pix_v;
  logic                init, run_act, tick, hit_any;
  logic [1:0]          level;
  logic [2:0]          step;
  int                  resp_cnt, nx, sc, dxp, dyp;

`ifdef GAP_RUNNER_SPEEDUP_EN
  assign level = ((score_q >> 3) > SCORE_W'(3)) ? 2'd3 : 2'(score_q >> 3);
`else
  assign level = 2'd0;
`endif
  assign step    = {1'b0, level} + 3'd1;
  assign hit_any = |hit_v;

  // A hit freezes the arena on the same edge that enters LOSE.
  always_comb begin
    state_d = state_q;
    init    = 1'b0;
    run_act = 1'b0;
    case (state_q)
      ST_IDLE, ST_LOSE: begin
        if (i_start) begin
          state_d = ST_RUN;
          init    = 1'b1;
        end
      end
      ST_RUN: begin
        if (hit_any) begin
          state_d = ST_LOSE;
        end else begin
          run_act = 1'b1;
          if (i_pause) state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (!i_pause) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tick = run_act && (timer_q == '1);

  always_comb begin
    resp_cnt = 0;
    for (int i = 0; i < NUM_OBST; i++) begin
      resp_cnt = resp_cnt + int'(respawn_v[i]);
    end
  end

  always_comb begin
    ball_x_d = ball_x_q;
    score_d  = score_q;
    hole_d   = hole_q;
    timer_d  = timer_q;
    nx       = 0;
    sc       = 0;
    if (init) begin
      ball_x_d = X_W'(FIELD_W / 2);
      score_d  = '0;
      hole_d   = X_W'(HOLE_INIT);
      timer_d  = '0;
    end else if (run_act) begin
      nx = int'(ball_x_q) + (i_mouse_dx_neg ? -int'(i_mouse_dx) : int'(i_mouse_dx));
      ball_x_d = X_W'(clamp_int(nx, PLAYER_R, FIELD_W - 1 - PLAYER_R));
      timer_d  = timer_q + 1'b1;
      if (resp_cnt != 0) begin
        sc      = int'(score_q) + resp_cnt;
        score_d = SCORE_W'((sc > SCORE_MAX) ? SCORE_MAX : sc);
        if (hole_q > X_W'(HOLE_MIN)) hole_d = hole_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= ST_IDLE;
      ball_x_q <= X_W'(FIELD_W / 2);
      score_q  <= '0;
      hole_q   <= X_W'(HOLE_INIT);
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      ball_x_q <= ball_x_d;
      score_q  <= score_d;
      hole_q   <= hole_d;
      timer_q  <= timer_d;
    end
  end

  for (genvar gi = 0; gi < NUM_OBST; gi++) begin : g_bar
    gap_runner_bar #(
      .IDX        (gi),
      .FIELD_W    (FIELD_W),
      .FIELD_H    (FIELD_H),
      .NUM_OBST   (NUM_OBST),
      .OBST_H     (OBST_H),
      .OBST_PITCH (OBST_PITCH),
      .PLAYER_R   (PLAYER_R),
      .HOLE_INIT  (HOLE_INIT)
    ) u_bar (
      .clk        (clk),
      .arst_n     (arst_n),
      .i_init     (init),
      .i_tick     (tick),
      .i_step     (step),
      .i_hole     (hole_q),
      .i_rand     (i_rand),
      .i_ball_x   (ball_x_q),
      .i_ball_y   (o_ball_y),
      .i_screen_x (i_screen_x),
      .i_screen_y (i_screen_y),
      .o_respawn  (respawn_v[gi]),
      .o_hit      (hit_v[gi]),
      .o_pix      (pix_v[gi])
    );
  end

  always_comb begin
    dxp         = int'(i_screen_x) - int'(ball_x_q);
    dyp         = int'(i_screen_y) - BALL_Y;
    o_is_player = (dxp >= -PLAYER_R) && (dxp <= PLAYER_R) &&
                  (dyp >= -PLAYER_R) && (dyp <= PLAYER_R);
  end

  assign o_is_obstacle = |pix_v;
  assign o_ball_x      = ball_x_q;
  assign o_ball_y      = Y_W'(BALL_Y);
  assign o_state       = state_q;
  assign o_score       = score_q;
  assign o_level       = level;

endmodule

// File: tb/tb_gap_runner_engine.sv
// Randomised bench for gap_runner_engine: a cycle-level game model pushes the
// expected view each cycle and a negedge monitor compares it with the DUT.
module tb_gap_runner_engine;
  import gap_runner_pkg::*;

  localparam int TW = 2;
  localparam int NB = 5;

  logic           clk = 1'b0;
  logic           arst_n;
  logic [7:0]     i_mouse_dx, i_rand;
  logic           i_mouse_dx_neg, i_start, i_pause;
  logic [X_W-1:0] i_screen_x;
  logic [Y_W-1:0] i_screen_y;
  logic           o_is_obstacle, o_is_player;
  logic [X_W-1:0] o_ball_x;
  logic [Y_W-1:0] o_ball_y;
  logic [1:0]     o_state, o_level;
  logic [9:0]     o_score;

  gap_runner_engine #(.TICK_W(TW)) dut (
    .clk(clk), .arst_n(arst_n), .i_mouse_dx(i_mouse_dx), .i_mouse_dx_neg(i_mouse_dx_neg),
    .i_rand(i_rand), .i_start(i_start), .i_pause(i_pause), .i_screen_x(i_screen_x),
    .i_screen_y(i_screen_y), .o_is_obstacle(o_is_obstacle), .o_is_player(o_is_player),
    .o_ball_x(o_ball_x), .o_ball_y(o_ball_y), .o_state(o_state), .o_score(o_score),
    .o_level(o_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st, bx, score, level, b0y, b0l, b0r;
    bit obs, ply;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference game state.
  int m_st, m_bx, m_score, m_hole, m_timer;
  int m_y[NB], m_l[NB], m_r[NB];
  bit rand_random, query_fixed;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_init();
    m_bx = 200; m_score = 0; m_hole = 75; m_timer = 0;
    for (int i = 0; i < NB; i++) begin
      m_y[i] = -(i + 1) * 140; m_l[i] = 125; m_r[i] = 275;
    end
  endtask

  task automatic model_reset();
    model_init();
    m_st = 0;
  endtask

  function automatic int m_level();
`ifdef GAP_RUNNER_SPEEDUP_EN
    return (m_score / 8 > 3) ? 3 : m_score / 8;
`else
    return 0;
`endif
  endfunction

  function automatic bit m_hit();
    for (int i = 0; i < NB; i++) begin
      if (m_y[i] <= 510 && m_y[i] + 19 >= 490 && (m_bx - 10 < m_l[i] || m_bx + 10 > m_r[i]))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_step();
    int cnt, c, st, lvl;
    case (m_st)
      0, 3: if (i_start) begin model_init(); m_st = 1; end
      2: if (!i_pause) m_st = 1;
      default: begin
        if (m_hit()) m_st = 3;
        else begin
          if (i_pause) m_st = 2;
          m_bx = clampi(m_bx + (i_mouse_dx_neg ? -int'(i_mouse_dx) : int'(i_mouse_dx)), 10, 389);
          m_timer = (m_timer + 1) % (1 << TW);
          if (m_timer == 0) begin
            lvl = m_level(); cnt = 0; st = lvl + 1;
            for (int i = 0; i < NB; i++) begin
              if (m_y[i] >= 600) begin
                m_y[i] -= 700;
                c = clampi(200 + int'($signed(i_rand)), m_hole, 399 - m_hole);
                m_l[i] = c - m_hole; m_r[i] = c + m_hole;
                cnt++;
              end else m_y[i] += st;
            end
            m_score = (m_score + cnt > 1023) ? 1023 : m_score + cnt;
            if (cnt > 0 && m_hole > 30) m_hole--;
          end
        end
      end
    endcase
  endtask

  task automatic push_exp();
    exp_t e;
    int sx, sy;
    sx = int'(i_screen_x); sy = int'(i_screen_y);
    e.st = m_st; e.bx = m_bx; e.score = m_score; e.level = m_level();
    e.b0y = m_y[0]; e.b0l = m_l[0]; e.b0r = m_r[0];
    e.obs = 1'b0;
    for (int i = 0; i < NB; i++)
      if (sy >= m_y[i] && sy <= m_y[i] + 19 && (sx < m_l[i] || sx > m_r[i])) e.obs = 1'b1;
    e.ply = (sx - m_bx >= -10) && (sx - m_bx <= 10) && (sy >= 490) && (sy <= 510);
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    if (arst_n) begin
      model_step();
      #3;
      if (arst_n) push_exp();
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("state", int'(o_state), e.st);
      chk("ball_x", int'(o_ball_x), e.bx);
      chk("ball_y", int'(o_ball_y), 500);
      chk("score", int'(o_score), e.score);
      chk("level", int'(o_level), e.level);
      chk("bar0_y", int'($signed(dut.g_bar[0].u_bar.bar_q.y)), e.b0y);
      chk("bar0_left", int'(dut.g_bar[0].u_bar.bar_q.left), e.b0l);
      chk("bar0_right", int'(dut.g_bar[0].u_bar.bar_q.right), e.b0r);
      chk("is_obstacle", int'(o_is_obstacle), int'(e.obs));
      chk("is_player", int'(o_is_player), int'(e.ply));
    end
  end

  task automatic new_query();
    int pick;
    if (!query_fixed) begin
      i_screen_x = X_W'($urandom_range(0, 399));
      pick = $urandom_range(0, 2);
      if (pick == 0) i_screen_y = Y_W'($urandom_range(0, 599));
      else if (pick == 1) i_screen_y = Y_W'($urandom_range(485, 515));
      else i_screen_y = Y_W'((m_y[0] >= 0 && m_y[0] < 590) ? m_y[0] + $urandom_range(0, 9) : 0);
    end
    if (rand_random) i_rand = 8'($urandom);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      new_query();
    end
  endtask

  task automatic wait_model(input string name, input int budget, input int want_st, input int want_score);
    int n;
    n = 0;
    while (n < budget && !(m_st == want_st || (want_score >= 0 && m_score >= want_score))) begin
      cyc(1);
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL %s: cycle budget %0d expired (state %0d score %0d)", name, budget, m_st, m_score);
    end
  endtask

  initial begin
    int hit_y;
    arst_n = 1'b0;
    i_mouse_dx = 8'd0; i_mouse_dx_neg = 1'b0; i_rand = 8'd0;
    i_start = 1'b0; i_pause = 1'b0;
    i_screen_x = '0; i_screen_y = '0;
    rand_random = 1'b0; query_fixed = 1'b0;
    model_reset();
    push_exp();
    repeat (3) @(posedge clk);
    #2 arst_n = 1'b1;
    $display("reset: state=%0d ball_x=%0d score=%0d", o_state, o_ball_x, o_score);

    i_pause = 1'b1; cyc(5); i_pause = 1'b0;
    $display("pause in idle: state=%0d", o_state);

    i_start = 1'b1; cyc(1); i_start = 1'b0;
    i_mouse_dx = 8'd255; cyc(3);
    i_mouse_dx_neg = 1'b1; cyc(3);
    i_mouse_dx = 8'd190; i_mouse_dx_neg = 1'b0; cyc(1);
    i_mouse_dx = 8'd0;
    $display("movement: ball_x=%0d", o_ball_x);

    wait_model("survive", 12000, 3, 9);
    chk("survive_state", int'(o_state), 1);
    chk("survive_score_ge9", int'(o_score >= 10'd9), 1);
    $display("survival: score=%0d level=%0d", o_score, o_level);

    i_pause = 1'b1; cyc(100);
    chk("pause_state", int'(o_state), 2);
    i_pause = 1'b0; cyc(3);
    $display("pause/resume: state=%0d", o_state);

    i_mouse_dx = 8'd170; i_mouse_dx_neg = 1'b1; cyc(1); i_mouse_dx = 8'd0;
    wait_model("collide", 4000, 3, -1);
    hit_y = 0;
    for (int i = 0; i < NB; i++) if (m_y[i] >= 471 && m_y[i] <= 510) hit_y = m_y[i];
    query_fixed = 1'b1; i_screen_x = '0; i_screen_y = Y_W'(hit_y);
    cyc(20);
    chk("lose_state", int'(o_state), 3);
    chk("lose_obstacle", int'(o_is_obstacle), 1);
    query_fixed = 1'b0;
    $display("collision: state=%0d score=%0d", o_state, o_score);

    i_rand = 8'h7F; i_start = 1'b1; cyc(1); i_start = 1'b0;
    wait_model("respawn_7f", 4000, 3, 1);
    chk("clamp_hi_left", int'(dut.g_bar[0].u_bar.bar_q.left), 249);
    chk("clamp_hi_right", int'(dut.g_bar[0].u_bar.bar_q.right), 399);
    i_rand = 8'h80;
    wait_model("respawn_80", 1500, 3, 2);
    chk("clamp_lo_left", int'(dut.g_bar[1].u_bar.bar_q.left), 0);
    chk("clamp_lo_right", int'(dut.g_bar[1].u_bar.bar_q.right), 148);
    $display("respawn clamp: bar0 %0d..%0d", dut.g_bar[0].u_bar.bar_q.left, dut.g_bar[0].u_bar.bar_q.right);

    rand_random = 1'b1;
    i_mouse_dx = 8'd3; cyc(40); i_mouse_dx = 8'd0;
    @(posedge clk); #2;
    arst_n = 1'b0;
    model_reset();
    exp_q.delete();
    push_exp();
    #1;
    chk("async_reset_state", int'(o_state), 0);
    chk("async_reset_ball", int'(o_ball_x), 200);
    cyc(2);
    arst_n = 1'b1;
    cyc(5);
    $display("mid-run reset: state=%0d ball_x=%0d", o_state, o_ball_x);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
